// File: rtl/rvfi_obi_responder.sv
// rvfi_obi_responder: protocol-legal OBI memory responder for a formal wrapper.
// Free random inputs are filtered so that grants and responses stay in order,
// the outstanding depth stays bounded and the latency stays bounded. A sticky
// checker flags requests that change or drop before they are granted.
// Optional macro RVFI_OBI_ERR_EN: when defined, err_o = rvalid_o & rand_err_i;
// when undefined, err_o is tied low and rand_err_i is ignored.
module rvfi_obi_responder #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_STALL       = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [ADDR_W-1:0]                      addr_i,
    input  logic                                   we_i,
    input  logic [DATA_W/8-1:0]                    be_i,
    input  logic [DATA_W-1:0]                      wdata_i,
    output logic                                   rvalid_o,
    output logic [DATA_W-1:0]                      rdata_o,
    output logic                                   err_o,
    input  logic                                   rand_gnt_i,
    input  logic                                   rand_rvalid_i,
    input  logic [DATA_W-1:0]                      rand_rdata_i,
    input  logic                                   rand_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int STL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

    localparam logic [CNT_W-1:0] MAX_OUT_C  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [STL_W-1:0] STL_MAX_C  = STL_W'(MAX_STALL);
    localparam logic             FORCE_EN_C = (MAX_STALL != 0) ? 1'b1 : 1'b0;

    // Pending-entry pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST_C) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    logic [CNT_W-1:0]            r_count;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [MAX_OUTSTANDING-1:0]  r_fifo_we;
    logic [STL_W-1:0]            r_gstall;
    logic [STL_W-1:0]            r_rstall;

    logic                        r_prev_req;
    logic                        r_prev_gnt;
    logic [ADDR_W-1:0]           r_prev_addr;
    logic                        r_prev_we;
    logic [DATA_W/8-1:0]         r_prev_be;
    logic [DATA_W-1:0]           r_prev_wdata;
    logic                        r_perr;

    logic                        w_room;
    logic                        w_gnt_force;
    logic                        w_rsp_force;
    logic                        w_head_we;
    logic                        w_violation;

    // Grant and response decisions: random choice, overridden once a stall limit is hit.
    always_comb begin
        w_room      = (r_count < MAX_OUT_C);
        w_gnt_force = FORCE_EN_C & (r_gstall == STL_MAX_C);
        w_rsp_force = FORCE_EN_C & (r_rstall == STL_MAX_C);
        w_head_we   = r_fifo_we[r_rd_ptr];
        if (reset) begin
            gnt_o    = 1'b0;
            rvalid_o = 1'b0;
        end else begin
            gnt_o    = req_i & w_room & (rand_gnt_i | w_gnt_force);
            rvalid_o = (r_count != '0) & (rand_rvalid_i | w_rsp_force);
        end
    end

    // Response payload: read data only on a read response, zero otherwise.
    always_comb begin
        if (rvalid_o && !w_head_we) begin
            rdata_o = rand_rdata_i;
        end else begin
            rdata_o = '0;
        end
`ifdef RVFI_OBI_ERR_EN
        err_o = rvalid_o & rand_err_i;
`else
        err_o = 1'b0;
`endif
    end

`ifndef RVFI_OBI_ERR_EN
    logic w_unused_rand_err;
    assign w_unused_rand_err = rand_err_i;
`endif

    // Pending FIFO, outstanding count and the two stall counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fifo_we <= '0;
            r_gstall  <= '0;
            r_rstall  <= '0;
        end else begin
            if (gnt_o) begin
                r_fifo_we[r_wr_ptr] <= we_i;
                r_wr_ptr            <= ptr_inc(r_wr_ptr);
            end
            if (rvalid_o) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(gnt_o) - CNT_W'(rvalid_o);
            if (!req_i || gnt_o) begin
                r_gstall <= '0;
            end else if (r_gstall != STL_MAX_C) begin
                r_gstall <= r_gstall + STL_W'(1);
            end
            if ((r_count == '0) || rvalid_o) begin
                r_rstall <= '0;
            end else if (r_rstall != STL_MAX_C) begin
                r_rstall <= r_rstall + STL_W'(1);
            end
        end
    end

    // A pending (ungranted) request must be held stable until it is granted.
    always_comb begin
        w_violation = r_prev_req & ~r_prev_gnt &
                      (~req_i | (addr_i != r_prev_addr) | (we_i != r_prev_we) |
                       (be_i != r_prev_be) | (r_prev_we & (wdata_i != r_prev_wdata)));
    end

    // Request-side history and the sticky violation flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_req   <= 1'b0;
            r_prev_gnt   <= 1'b0;
            r_prev_addr  <= '0;
            r_prev_we    <= 1'b0;
            r_prev_be    <= '0;
            r_prev_wdata <= '0;
            r_perr       <= 1'b0;
        end else begin
            r_prev_req   <= req_i;
            r_prev_gnt   <= gnt_o;
            r_prev_addr  <= addr_i;
            r_prev_we    <= we_i;
            r_prev_be    <= be_i;
            r_prev_wdata <= wdata_i;
            r_perr       <= r_perr | w_violation;
        end
    end

    assign outstanding_o  = r_count;
    assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_rvfi_obi_responder.sv
// Self-checking bench for rvfi_obi_responder. u_dut uses MAX_STALL=4 and is
// checked every cycle against a reference model whose pending queue acts as the
// response scoreboard; u_dut0 uses MAX_STALL=0 for the full-FIFO scenario.
module tb_rvfi_obi_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int MS = 4;
    localparam int CW = $clog2(MO + 1);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          req_i;
    logic [AW-1:0] addr_i;
    logic          we_i;
    logic [DW/8-1:0] be_i;
    logic [DW-1:0] wdata_i;
    logic          rand_gnt_i;
    logic          rand_rvalid_i;
    logic [DW-1:0] rand_rdata_i;
    logic          rand_err_i;

    logic          gnt_o, rvalid_o, err_o, protocol_err_o;
    logic [DW-1:0] rdata_o;
    logic [CW-1:0] outstanding_o;

    logic          gnt0, rv0, err0, perr0;
    logic [DW-1:0] rdata0;
    logic [CW-1:0] out0;

    rvfi_obi_responder #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTSTANDING(MO), .MAX_STALL(MS)) u_dut (
        .clock(clock), .reset(reset), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .rand_gnt_i(rand_gnt_i), .rand_rvalid_i(rand_rvalid_i),
        .rand_rdata_i(rand_rdata_i), .rand_err_i(rand_err_i), .outstanding_o(outstanding_o),
        .protocol_err_o(protocol_err_o)
    );

    rvfi_obi_responder #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTSTANDING(MO), .MAX_STALL(0)) u_dut0 (
        .clock(clock), .reset(reset), .req_i(req_i), .gnt_o(gnt0), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rv0), .rdata_o(rdata0),
        .err_o(err0), .rand_gnt_i(rand_gnt_i), .rand_rvalid_i(rand_rvalid_i),
        .rand_rdata_i(rand_rdata_i), .rand_err_i(rand_err_i), .outstanding_o(out0),
        .protocol_err_o(perr0)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic          q_we[$];
    int            m_gstall = 0;
    int            m_rstall = 0;
    logic          m_perr = 1'b0;
    logic          m_last_gnt = 1'b0;
    logic          p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW/8-1:0] p_be = '0;
    logic [DW-1:0] p_wdata = '0;

    // samples taken before each clock edge
    logic          s_gnt, s_rv, s_err, s_perr, s0_gnt, s0_rv;
    logic [DW-1:0] s_rdata;
    logic [CW-1:0] s_out, s0_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        logic          e_gnt, e_rv, e_err;
        logic [DW-1:0] e_rdata;
        int            cnt;
        #1;
        cnt   = q_we.size();
        e_gnt = !reset && req_i && (cnt < MO) && (rand_gnt_i || (m_gstall == MS));
        e_rv  = !reset && (cnt != 0) && (rand_rvalid_i || (m_rstall == MS));
        e_rdata = '0;
        if (e_rv) begin
            if (!q_we[0]) e_rdata = rand_rdata_i;
        end
        e_err = 1'b0;
`ifdef RVFI_OBI_ERR_EN
        e_err = e_rv && rand_err_i;
`endif
        s_gnt = gnt_o; s_rv = rvalid_o; s_rdata = rdata_o; s_err = err_o;
        s_out = outstanding_o; s_perr = protocol_err_o;
        s0_gnt = gnt0; s0_rv = rv0; s0_out = out0;
        chk({tag, ".gnt"},    64'(gnt_o),          64'(e_gnt));
        chk({tag, ".rvalid"}, 64'(rvalid_o),       64'(e_rv));
        chk({tag, ".rdata"},  64'(rdata_o),        64'(e_rdata));
        chk({tag, ".err"},    64'(err_o),          64'(e_err));
        chk({tag, ".outst"},  64'(outstanding_o),  64'(cnt));
        chk({tag, ".perr"},   64'(protocol_err_o), 64'(m_perr));
        @(posedge clock);
        if (reset) begin
            q_we.delete();
            m_gstall = 0; m_rstall = 0; m_perr = 1'b0;
            p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0;
            p_addr = '0; p_be = '0; p_wdata = '0;
            m_last_gnt = 1'b0;
        end else begin
            if (p_req && !p_gnt && (!req_i || (addr_i != p_addr) || (we_i != p_we) ||
                                    (be_i != p_be) || (p_we && (wdata_i != p_wdata))))
                m_perr = 1'b1;
            if (!req_i || e_gnt) m_gstall = 0;
            else if (m_gstall < MS) m_gstall++;
            if ((cnt == 0) || e_rv) m_rstall = 0;
            else if (m_rstall < MS) m_rstall++;
            if (e_rv) void'(q_we.pop_front());
            if (e_gnt) q_we.push_back(we_i);
            p_req = req_i; p_gnt = e_gnt; p_we = we_i;
            p_addr = addr_i; p_be = be_i; p_wdata = wdata_i;
            m_last_gnt = e_gnt;
        end
        #1;
    endtask

    initial begin
        logic exp_err;
        reset = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = 4'hF; wdata_i = '0;
        rand_gnt_i = 1'b0; rand_rvalid_i = 1'b0; rand_rdata_i = '0; rand_err_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // reset stall
        req_i = 1'b1; addr_i = 32'h10; rand_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("rst");
            chk("rst_gnt", 64'(s_gnt), 64'd0);
        end
        reset = 1'b0;
        cycle("rel");
        chk("rel_gnt", 64'(s_gnt), 64'd1);
        req_i = 1'b0; rand_gnt_i = 1'b0;
        cycle("rel2");
        chk("rel_outst", 64'(s_out), 64'd1);
        rand_rvalid_i = 1'b1; rand_rdata_i = 32'hA5A5_0001;
        cycle("rel3");
        chk("rel_rdata", 64'(s_rdata), 64'hA5A5_0001);

        // latency / ordering
        rand_rvalid_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h200; rand_gnt_i = 1'b1;
        cycle("lat_a");
        chk("lat_a_gnt", 64'(s_gnt), 64'd1);
        we_i = 1'b1; addr_i = 32'h204; wdata_i = 32'hCAFE; rand_rvalid_i = 1'b1;
        rand_rdata_i = 32'hDEAD_BEEF; rand_err_i = 1'b1;
        cycle("lat_b");
        chk("lat_b_rv", 64'(s_rv), 64'd1);
        chk("lat_b_rdata", 64'(s_rdata), 64'hDEAD_BEEF);
        chk("lat_b_outst", 64'(s_out), 64'd1);
`ifdef RVFI_OBI_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("lat_b_err", 64'(s_err), 64'(exp_err));
        req_i = 1'b0; rand_rdata_i = 32'h1234_5678; rand_err_i = 1'b0;
        cycle("lat_c");
        chk("lat_c_rv", 64'(s_rv), 64'd1);
        chk("lat_c_rdata", 64'(s_rdata), 64'd0);
        chk("lat_c_outst", 64'(s_out), 64'd1);
        rand_rvalid_i = 1'b0;
        cycle("lat_d");
        chk("lat_d_outst", 64'(s_out), 64'd0);

        // full FIFO, no forcing on u_dut0
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300; rand_gnt_i = 1'b1;
        cycle("full_a");
        addr_i = 32'h304;
        cycle("full_b");
        addr_i = 32'h308;
        cycle("full_c");
        chk("full_c_gnt0", 64'(s0_gnt), 64'd0);
        chk("full_c_out0", 64'(s0_out), 64'd2);
        cycle("full_d");
        chk("full_d_gnt0", 64'(s0_gnt), 64'd0);
        rand_rvalid_i = 1'b1;
        cycle("full_e");
        chk("full_e_rv0", 64'(s0_rv), 64'd1);
        chk("full_e_gnt0", 64'(s0_gnt), 64'd0);
        rand_rvalid_i = 1'b0;
        cycle("full_f");
        chk("full_f_gnt0", 64'(s0_gnt), 64'd1);
        req_i = 1'b0; rand_rvalid_i = 1'b1;
        repeat (3) cycle("full_drain");

        // fairness: forced grant then forced response
        rand_rvalid_i = 1'b0; rand_gnt_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h400;
        for (int i = 1; i <= 5; i++) begin
            cycle("fair_g");
            chk("fair_gnt", 64'(s_gnt), 64'(i == 5));
        end
        req_i = 1'b0; rand_rdata_i = 32'h0BAD_F00D;
        for (int i = 1; i <= 5; i++) begin
            cycle("fair_r");
            chk("fair_rv", 64'(s_rv), 64'(i == 5));
        end

        // protocol checker
        reset = 1'b1; cycle("p_rst"); reset = 1'b0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; rand_gnt_i = 1'b0;
        cycle("p1");
        addr_i = 32'h104;
        cycle("p2");
        chk("p2_perr", 64'(s_perr), 64'd0);
        cycle("p3");
        chk("p3_perr", 64'(s_perr), 64'd1);
        req_i = 1'b0;
        cycle("p4");
        cycle("p5");
        chk("p5_perr", 64'(s_perr), 64'd1);
        reset = 1'b1; cycle("p_rst2"); reset = 1'b0;
        cycle("p6");
        chk("p6_perr", 64'(s_perr), 64'd0);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h500; wdata_i = 32'd1;
        cycle("p7");
        wdata_i = 32'd2;
        cycle("p8");
        cycle("p9");
        chk("p9_perr_rd_wdata", 64'(s_perr), 64'd0);
        rand_gnt_i = 1'b1;
        cycle("p10");
        we_i = 1'b1; addr_i = 32'h504; wdata_i = 32'd5; rand_gnt_i = 1'b0;
        cycle("p11");
        wdata_i = 32'd6;
        cycle("p12");
        cycle("p13");
        chk("p13_perr_wr_wdata", 64'(s_perr), 64'd1);

        // reset mid-transaction
        reset = 1'b1; req_i = 1'b0; cycle("mid_r0"); reset = 1'b0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h600; rand_gnt_i = 1'b1; rand_rvalid_i = 1'b0;
        cycle("mid_a");
        req_i = 1'b0; reset = 1'b1; rand_rvalid_i = 1'b1;
        cycle("mid_rst");
        chk("mid_rst_rv", 64'(s_rv), 64'd0);
        reset = 1'b0;
        cycle("mid_b");
        chk("mid_b_rv", 64'(s_rv), 64'd0);
        chk("mid_b_outst", 64'(s_out), 64'd0);

        // constrained-random traffic that keeps pending requests stable
        for (int i = 0; i < 80; i++) begin
            if (!(req_i && !m_last_gnt)) begin
                req_i   = 1'($urandom_range(0, 1));
                we_i    = 1'($urandom_range(0, 1));
                addr_i  = $urandom;
                be_i    = 4'($urandom);
                wdata_i = $urandom;
            end
            rand_gnt_i    = 1'($urandom_range(0, 1));
            rand_rvalid_i = 1'($urandom_range(0, 1));
            rand_rdata_i  = $urandom;
            rand_err_i    = 1'($urandom_range(0, 1));
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_obi_responder.md
Name: rvfi_obi_responder

Overview:
- Parametrised, protocol-compliant memory responder for one OBI-style req/gnt/rvalid port of a core under formal check (instruction or data side).
- Replaces free random bus inputs in the riscv-formal wrapper: randomness still comes from free inputs driven by `rvformal_rand_reg`, but is filtered so grant/response ordering, outstanding depth and bounded latency are always legal.
- Adds sticky protocol checking of the core's request side.
- One instance per bus port in the core wrapper.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address width.
- MAX_OUTSTANDING, 2, granted-but-unanswered transactions allowed (>=1).
- MAX_STALL, 4, consecutive stalled cycles before grant/response is forced; 0 = no forcing (pure random).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  1  core request.
- gnt_o  out  1  grant to core.
- addr_i  in  ADDR_W  request address.
- we_i  in  1  write enable.
- be_i  in  DATA_W/8  byte enables.
- wdata_i  in  DATA_W  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_W  response read data.
- err_o  out  1  response error.
- rand_gnt_i  in  1  nondeterministic grant choice.
- rand_rvalid_i  in  1  nondeterministic response choice.
- rand_rdata_i  in  DATA_W  nondeterministic read data.
- rand_err_i  in  1  nondeterministic error choice.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
- protocol_err_o  out  1  sticky request-side protocol violation.

Behaviour:
- Reset: while reset=1, gnt_o=0 and rvalid_o=0. Synchronous reset clears count, FIFO pointers, both stall counters and protocol_err_o. err_o=0, rdata_o=0, outstanding_o=0 after reset.
- Room: room = (count < MAX_OUTSTANDING). There is no same-cycle push/pop bypass when full.
- gnt_o (combinational) = !reset & req_i & room & (rand_gnt_i | gnt_force).
  - gnt_force = (MAX_STALL!=0) & (gstall == MAX_STALL).
- gstall counter:
  - Increments when req_i & !gnt_o, saturating at MAX_STALL.
  - Clears when gnt_o or !req_i.
  - Stalls caused by !room also count; force takes effect once room appears.
- Pending FIFO (depth MAX_OUTSTANDING, in order):
  - Push {we_i} on gnt_o.
  - Pop on rvalid_o.
- rvalid_o (combinational) = !reset & (count != 0) & (rand_rvalid_i | rsp_force).
  - rsp_force uses counter rstall with the same rules as gstall, counting cycles with count!=0 & !rvalid_o.
  - Minimum grant-to-rvalid latency is 1 cycle, because count is registered and the entry is visible the cycle after the grant.
- rdata_o:
  - rand_rdata_i when rvalid_o and the head entry is a read.
  - 0 when the response is a write response or rvalid_o=0.
- Count update: count_next = count + push - pop. Simultaneous push and pop leaves count unchanged. outstanding_o = count.
- Protocol checker: registers req_i, addr_i, we_i, be_i, wdata_i and gnt_o each cycle. If the previous cycle had req_i=1 & gnt_o=0, then this cycle any of the following sets protocol_err_o (sticky until reset):
  - req_i=0;
  - addr/we/be changed;
  - wdata changed while we=1.
- Reset mid-transaction: all pending entries are discarded. No rvalid_o follows for transactions granted before reset.

Optional Feature:
- Macro: RVFI_OBI_ERR_EN.
- Defined: err_o = rvalid_o & rand_err_i. On an errored read, rdata_o is still rand_rdata_i; the core must ignore it.
- Undefined: err_o tied 0 and rand_err_i unused.

Test Plan:
- Reset stall: hold reset=1 for 3 cycles with req_i=1, rand_gnt_i=1 -> gnt_o=0 throughout; after release gnt_o=1 the first cycle; outstanding_o=1 the next cycle.
- Latency/ordering: MAX_OUTSTANDING=2; read A granted at cycle t, write B at t+1, rand_rvalid_i=1 from t+1 -> rvalid_o at t+1 with rdata_o=rand_rdata_i, then at t+2 with rdata_o=0; outstanding_o sequence 1,1,0.
- Full: two grants with rand_rvalid_i=0, MAX_STALL=0 -> outstanding_o=2 and gnt_o=0 despite rand_gnt_i=1; one rvalid_o -> grant allowed the following cycle.
- Fairness: MAX_STALL=4, req_i=1, rand_gnt_i=0 -> gnt_o asserts on the 5th request cycle. Likewise rvalid_o forced 5 cycles after the entry becomes visible.
- Protocol: req_i=1 ungranted with addr 0x100, next cycle addr 0x104 -> protocol_err_o=1 next cycle and remains 1 until reset.
- Error (RVFI_OBI_ERR_EN defined): rand_err_i=1 with rvalid_o -> err_o=1 in the same cycle. With the macro undefined, err_o stays 0.
